// File: rtl/control_fsm_pkg.sv
// Shared types for the multi-cycle control FSM: opcodes, ALU functions,
// offset selects, exception causes, FSM states and the registered control word.
package control_fsm_pkg;

  typedef enum logic [3:0] {
    OP_ARITHM = 4'h0,
    OP_LW     = 4'h1,
    OP_SW     = 4'h2,
    OP_BLT    = 4'h3,
    OP_BGT    = 4'h4,
    OP_BE     = 4'h5,
    OP_JMP    = 4'h6,
    OP_HALT   = 4'h7
  } opcode_t;

  typedef enum logic [3:0] {
    C_ADD = 4'h0, C_SUB = 4'h1, C_MUL = 4'h2, C_DIV = 4'h3,
    C_AND = 4'h4, C_OR  = 4'h5, C_XOR = 4'h6, C_NOT = 4'h7,
    C_ROR = 4'h8, C_ROL = 4'h9, C_SHL = 4'hA, C_SHR = 4'hB
  } control_e;

  typedef enum logic [1:0] {
    SEL_NONE      = 2'd0,
    SEL_FOURBIT   = 2'd1,
    SEL_EIGHTBIT  = 2'd2,
    SEL_TWELVEBIT = 2'd3
  } sel_t;

  typedef enum logic [2:0] {
    EXC_NONE    = 3'd0,
    EXC_DIV0    = 3'd1,
    EXC_OVF     = 3'd2,
    EXC_ILLEGAL = 3'd3,
    EXC_TIMEOUT = 3'd4
  } exc_cause_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_MEM  = 2'd1,
    ST_HALT = 2'd2,
    ST_EXC  = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic alu_op;
    sel_t offset_sel;
    logic mem2r;
    logic r0_read;
    logic se_imm_a;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_WORD_RESET = '{
    alu_op: 1'b0, offset_sel: SEL_NONE, mem2r: 1'b0, r0_read: 1'b0, se_imm_a: 1'b0
  };

  function automatic logic is_shift(input control_e f);
    return (f == C_ROR) || (f == C_ROL) || (f == C_SHL) || (f == C_SHR);
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Fetch / datapath / data-memory side bundle of the control FSM.
// master: driven by fetch, ALU and memory; slave: the control FSM itself.
interface control_fsm_if import control_fsm_pkg::*; #(
  parameter int unsigned CNT_W = 16
) ();

  logic             instr_valid;
  logic             instr_ready;
  opcode_t          opcode;
  control_e         func;
  logic             div0;
  logic             overflow;
  logic             mem_ack;
  logic             mem_req;
  logic             ctrl_valid;
  logic             alu_op;
  sel_t             offset_sel;
  logic             mem2r;
  logic             memwr;
  logic             reg_wr;
  logic             r0_read;
  logic             se_imm_a;
  logic             halt_sys;
  logic             exc_flag;
  exc_cause_e       exc_cause;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output instr_valid, opcode, func, div0, overflow, mem_ack,
    input  instr_ready, mem_req, ctrl_valid, alu_op, offset_sel, mem2r, memwr,
           reg_wr, r0_read, se_imm_a, halt_sys, exc_flag, exc_cause, retire_cnt
  );

  modport slave (
    input  instr_valid, opcode, func, div0, overflow, mem_ack,
    output instr_ready, mem_req, ctrl_valid, alu_op, offset_sel, mem2r, memwr,
           reg_wr, r0_read, se_imm_a, halt_sys, exc_flag, exc_cause, retire_cnt
  );

endinterface

// File: rtl/control_fsm_ctrl_decode.sv
// Pure combinational opcode/func to control-word decoder; unlisted opcodes
// raise o_illegal and produce the reset word.
module ctrl_decode import control_fsm_pkg::*; (
  input  opcode_t    i_opcode,
  input  control_e   i_func,
  output ctrl_word_t o_word,
  output logic       o_illegal
);

  always_comb begin
    o_word    = CTRL_WORD_RESET;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_ARITHM: begin
        o_word.offset_sel = is_shift(i_func) ? SEL_FOURBIT : SEL_NONE;
        o_word.se_imm_a   = 1'b1;
      end
      OP_LW: begin
        o_word.alu_op     = 1'b1;
        o_word.offset_sel = SEL_EIGHTBIT;
        o_word.mem2r      = 1'b1;
      end
      OP_SW: begin
        o_word.alu_op     = 1'b1;
        o_word.offset_sel = SEL_EIGHTBIT;
      end
      OP_BLT, OP_BGT, OP_BE: begin
        o_word.offset_sel = SEL_EIGHTBIT;
        o_word.r0_read    = 1'b1;
        o_word.se_imm_a   = 1'b1;
      end
      OP_JMP: begin
        o_word.offset_sel = SEL_TWELVEBIT;
        o_word.se_imm_a   = 1'b1;
      end
      OP_HALT: o_word.se_imm_a = 1'b1;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle control FSM: registers decoded control words, sequences LW/SW
// through mem_req/mem_ack and latches exceptions into a sticky halt.
// Optional memory timeout enabled by defining CTRL_MEM_TIMEOUT_EN.
module control_fsm import control_fsm_pkg::*; #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 16
) (
  input logic          clk,
  input logic          rst,
  control_fsm_if.slave bus
);

  ctrl_state_e      r_state, w_state_nxt;
  exc_cause_e       r_cause, w_cause_nxt;
  ctrl_word_t       r_word, w_dec_word;
  opcode_t          r_op;
  logic             r_ctrl_valid;
  logic [CNT_W-1:0] r_retire;

  logic w_dec_illegal;
  logic w_accept;
  logic w_arith_cv;
  logic w_alu_exc;
  logic w_load;
  logic w_mem_done;
  logic w_retire_on_valid;
  logic w_retire_inc;
  logic w_timeout;
  logic w_reg_wr;
  logic w_mem_req;

  ctrl_decode u_decode (
    .i_opcode  (bus.opcode),
    .i_func    (bus.func),
    .o_word    (w_dec_word),
    .o_illegal (w_dec_illegal)
  );

  assign w_accept          = bus.instr_valid & (r_state == ST_RUN);
  assign w_arith_cv        = r_ctrl_valid & (r_op == OP_ARITHM);
  assign w_alu_exc         = w_arith_cv & (bus.div0 | bus.overflow);
  // An instruction accepted in the excepting cycle is dropped, never retired.
  assign w_load            = w_accept & ~w_alu_exc;
  assign w_mem_done        = (r_state == ST_MEM) & bus.mem_ack;
  assign w_retire_on_valid = r_op inside {OP_ARITHM, OP_BLT, OP_BGT, OP_BE, OP_JMP, OP_HALT};
  assign w_retire_inc      = (r_ctrl_valid & w_retire_on_valid & ~w_alu_exc) | w_mem_done;

`ifdef CTRL_MEM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tcnt;

  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_MEM)) r_tcnt <= '0;
    else if (!bus.mem_ack)          r_tcnt <= r_tcnt + 1'b1;
  end

  // Fires in the TIMEOUT_CYCLES-th MEM cycle without ack; an ack there wins.
  assign w_timeout = (r_state == ST_MEM) & ~bus.mem_ack &
                     ((32'(r_tcnt) + 32'd1) == 32'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    w_mem_req   = 1'b0;
    w_reg_wr    = (w_arith_cv & ~(bus.div0 | bus.overflow)) | (w_mem_done & (r_op == OP_LW));
    case (r_state)
      ST_RUN: begin
        if (w_alu_exc) begin
          w_state_nxt = ST_EXC;
          w_cause_nxt = bus.div0 ? EXC_DIV0 : EXC_OVF;
        end else if (w_accept) begin
          if (w_dec_illegal) begin
            w_state_nxt = ST_EXC;
            w_cause_nxt = EXC_ILLEGAL;
          end else if ((bus.opcode == OP_LW) || (bus.opcode == OP_SW)) begin
            w_state_nxt = ST_MEM;
          end else if (bus.opcode == OP_HALT) begin
            w_state_nxt = ST_HALT;
          end
        end
      end
      ST_MEM: begin
        w_mem_req = 1'b1;
        if (bus.mem_ack) begin
          w_state_nxt = ST_RUN;
        end else if (w_timeout) begin
          w_state_nxt = ST_EXC;
          w_cause_nxt = EXC_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_cause      <= EXC_NONE;
      r_word       <= CTRL_WORD_RESET;
      r_op         <= OP_ARITHM;
      r_ctrl_valid <= 1'b0;
      r_retire     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cause      <= w_cause_nxt;
      r_ctrl_valid <= w_load;
      if (w_load) begin
        r_word <= w_dec_word;
        r_op   <= bus.opcode;
      end
      if (w_retire_inc) r_retire <= r_retire + 1'b1;
    end
  end

  assign bus.instr_ready = (r_state == ST_RUN);
  assign bus.mem_req     = w_mem_req;
  assign bus.memwr       = w_mem_req & (r_op == OP_SW);
  assign bus.reg_wr      = w_reg_wr;
  assign bus.ctrl_valid  = r_ctrl_valid;
  assign bus.alu_op      = r_word.alu_op;
  assign bus.offset_sel  = r_word.offset_sel;
  assign bus.mem2r       = r_word.mem2r;
  assign bus.r0_read     = r_word.r0_read;
  assign bus.se_imm_a    = r_word.se_imm_a;
  assign bus.halt_sys    = (r_state == ST_HALT) | (r_state == ST_EXC);
  assign bus.exc_flag    = (r_state == ST_EXC);
  assign bus.exc_cause   = r_cause;
  assign bus.retire_cnt  = r_retire;

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: per-cycle vector table with a queue
// of expected observations, plus hand sequences for the memory timeout.
module tb_control_fsm;
  import control_fsm_pkg::*;

  logic clk;
  logic rst;

  control_fsm_if #(.CNT_W(16)) bus ();

  control_fsm #(.TIMEOUT_CYCLES(4), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy;
    logic       cv;
    logic       alu;
    sel_t       off;
    logic       m2r;
    logic       r0;
    logic       se;
    logic       rw;
    logic       mreq;
    logic       mwr;
    logic       halt;
    logic       exc;
    exc_cause_e cause;
    logic [15:0] cnt;
  } obs_t;

  typedef struct {
    logic     v;
    opcode_t  op;
    control_e fn;
    logic     d0;
    logic     ov;
    logic     ack;
    logic     rs;
    obs_t     exp;
  } vec_t;

  int   n_checks = 0;
  int   n_err    = 0;
  vec_t vecs[$];
  obs_t exp_q[$];

  function automatic obs_t o(input logic rdy, cv, alu, input sel_t off,
                             input logic m2r, r0, se, rw, mreq, mwr, halt, exc,
                             input exc_cause_e cause, input int cnt);
    obs_t r;
    r = '{rdy: rdy, cv: cv, alu: alu, off: off, m2r: m2r, r0: r0, se: se, rw: rw,
          mreq: mreq, mwr: mwr, halt: halt, exc: exc, cause: cause, cnt: 16'(cnt)};
    return r;
  endfunction

  function automatic vec_t iv(input logic v, input opcode_t op, input control_e fn,
                              input logic d0, ov, ack, rs, input obs_t exp);
    vec_t r;
    r = '{v: v, op: op, fn: fn, d0: d0, ov: ov, ack: ack, rs: rs, exp: exp};
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r = '{rdy: bus.instr_ready, cv: bus.ctrl_valid, alu: bus.alu_op, off: bus.offset_sel,
          m2r: bus.mem2r, r0: bus.r0_read, se: bus.se_imm_a, rw: bus.reg_wr,
          mreq: bus.mem_req, mwr: bus.memwr, halt: bus.halt_sys, exc: bus.exc_flag,
          cause: bus.exc_cause, cnt: bus.retire_cnt};
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst             = v.rs;
    bus.instr_valid = v.v;
    bus.opcode      = v.op;
    bus.func        = v.fn;
    bus.div0        = v.d0;
    bus.overflow    = v.ov;
    bus.mem_ack     = v.ack;
  endtask

  task automatic idle();
    drive(iv(1'b0, OP_ARITHM, C_ADD, 1'b0, 1'b0, 1'b0, 1'b0, '0));
  endtask

  obs_t    RSTO, LWW, EXD, OVE;
  opcode_t op_bad;
  int      mem_cycles;
  int      waited;

  initial begin
    RSTO   = o(1,0,0,SEL_NONE,    0,0,0,0,0,0,0,0,EXC_NONE,0);
    LWW    = o(0,0,1,SEL_EIGHTBIT,1,0,0,0,1,0,0,0,EXC_NONE,2);
    EXD    = o(0,0,0,SEL_NONE,    0,0,1,0,0,0,1,1,EXC_DIV0,6);
    OVE    = o(0,0,0,SEL_FOURBIT, 0,0,1,0,0,0,1,1,EXC_OVF,0);
    op_bad = opcode_t'(4'hF);

    // back-to-back ARITHM
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,0,0, RSTO));
    vecs.push_back(iv(1,OP_ARITHM,C_ROL,0,0,0,0, RSTO));
    vecs.push_back(iv(1,OP_ARITHM,C_ADD,0,0,0,0, o(1,1,0,SEL_FOURBIT,0,0,1,1,0,0,0,0,EXC_NONE,0)));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,0,0, o(1,1,0,SEL_NONE,0,0,1,1,0,0,0,0,EXC_NONE,1)));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,0,0, o(1,0,0,SEL_NONE,0,0,1,0,0,0,0,0,EXC_NONE,2)));
    // LW, ack three cycles after mem_req rises; stray ack in RUN ignored
    vecs.push_back(iv(1,OP_LW,C_ADD,0,0,0,0, o(1,0,0,SEL_NONE,0,0,1,0,0,0,0,0,EXC_NONE,2)));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,0,0, o(0,1,1,SEL_EIGHTBIT,1,0,0,0,1,0,0,0,EXC_NONE,2)));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,0,0, LWW));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,0,0, LWW));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,1,0, o(0,0,1,SEL_EIGHTBIT,1,0,0,1,1,0,0,0,EXC_NONE,2)));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,1,0, o(1,0,1,SEL_EIGHTBIT,1,0,0,0,0,0,0,0,EXC_NONE,3)));
    // SW
    vecs.push_back(iv(1,OP_SW,C_ADD,0,0,0,0, o(1,0,1,SEL_EIGHTBIT,1,0,0,0,0,0,0,0,EXC_NONE,3)));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,0,0, o(0,1,1,SEL_EIGHTBIT,0,0,0,0,1,1,0,0,EXC_NONE,3)));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,1,0, o(0,0,1,SEL_EIGHTBIT,0,0,0,0,1,1,0,0,EXC_NONE,3)));
    // branch and jump
    vecs.push_back(iv(1,OP_BLT,C_ADD,0,0,0,0, o(1,0,1,SEL_EIGHTBIT,0,0,0,0,0,0,0,0,EXC_NONE,4)));
    vecs.push_back(iv(1,OP_JMP,C_ADD,0,0,0,0, o(1,1,0,SEL_EIGHTBIT,0,1,1,0,0,0,0,0,EXC_NONE,4)));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,0,0, o(1,1,0,SEL_TWELVEBIT,0,0,1,0,0,0,0,0,EXC_NONE,5)));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,0,0, o(1,0,0,SEL_TWELVEBIT,0,0,1,0,0,0,0,0,EXC_NONE,6)));
    // div0 + overflow together; the ADD accepted in that cycle is discarded
    vecs.push_back(iv(1,OP_ARITHM,C_SUB,0,0,0,0, o(1,0,0,SEL_TWELVEBIT,0,0,1,0,0,0,0,0,EXC_NONE,6)));
    vecs.push_back(iv(1,OP_ARITHM,C_ADD,1,1,0,0, o(1,1,0,SEL_NONE,0,0,1,0,0,0,0,0,EXC_NONE,6)));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,0,0, EXD));
    vecs.push_back(iv(1,OP_ARITHM,C_ADD,0,0,0,0, EXD));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,0,1, EXD));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,0,0, RSTO));
    // illegal opcode, then reset out of EXC
    vecs.push_back(iv(1,op_bad,C_ADD,0,0,0,0, RSTO));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,0,0, o(0,1,0,SEL_NONE,0,0,0,0,0,0,1,1,EXC_ILLEGAL,0)));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,0,1, o(0,0,0,SEL_NONE,0,0,0,0,0,0,1,1,EXC_ILLEGAL,0)));
    // reset in the middle of MEM
    vecs.push_back(iv(1,OP_LW,C_ADD,0,0,0,0, RSTO));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,0,0, o(0,1,1,SEL_EIGHTBIT,1,0,0,0,1,0,0,0,EXC_NONE,0)));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,0,1, o(0,0,1,SEL_EIGHTBIT,1,0,0,0,1,0,0,0,EXC_NONE,0)));
    // HALT is sticky and retires once
    vecs.push_back(iv(1,OP_HALT,C_ADD,0,0,0,0, RSTO));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,0,0, o(0,1,0,SEL_NONE,0,0,1,0,0,0,1,0,EXC_NONE,0)));
    vecs.push_back(iv(1,OP_ARITHM,C_ADD,0,0,0,0, o(0,0,0,SEL_NONE,0,0,1,0,0,0,1,0,EXC_NONE,1)));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,0,1, o(0,0,0,SEL_NONE,0,0,1,0,0,0,1,0,EXC_NONE,1)));
    // overflow alone
    vecs.push_back(iv(1,OP_ARITHM,C_SHR,0,0,0,0, RSTO));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,1,0,0, o(1,1,0,SEL_FOURBIT,0,0,1,0,0,0,0,0,EXC_NONE,0)));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,0,0, OVE));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,0,1, OVE));
    vecs.push_back(iv(0,OP_ARITHM,C_ADD,0,0,0,0, RSTO));

    idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      exp_q.push_back(vecs[i].exp);
      #2;
      chk($sformatf("row%0d", i), 32'(sample()), 32'(exp_q.pop_front()));
    end

`ifdef CTRL_MEM_TIMEOUT_EN
    // LW with no ack: EXC/TIMEOUT after four MEM cycles
    @(negedge clk);
    idle();
    bus.instr_valid = 1'b1;
    bus.opcode      = OP_LW;
    @(negedge clk);
    idle();
    mem_cycles = 0;
    waited     = 0;
    while (!bus.exc_flag && waited < 20) begin
      #2;
      if (bus.mem_req) mem_cycles++;
      @(negedge clk);
      waited++;
    end
    #2;
    chk("to_mem_cycles", 32'(mem_cycles), 32'd4);
    chk("to_exc_flag", 32'(bus.exc_flag), 32'd1);
    chk("to_cause", 32'(bus.exc_cause), 32'(EXC_TIMEOUT));
    chk("to_mem_req", 32'(bus.mem_req), 32'd0);

    // LW with ack on the limit cycle: normal completion
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.instr_valid = 1'b1;
    bus.opcode      = OP_LW;
    @(negedge clk);
    idle();
    mem_cycles = 0;
    while (bus.mem_req && mem_cycles < 20) begin
      mem_cycles++;
      bus.mem_ack = (mem_cycles == 4);
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    #2;
    chk("ack_mem_cycles", 32'(mem_cycles), 32'd4);
    chk("ack_ready", 32'(bus.instr_ready), 32'd1);
    chk("ack_exc_flag", 32'(bus.exc_flag), 32'd0);
    chk("ack_retire", 32'(bus.retire_cnt), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
